// File: rtl/data_bus_pkg.sv
// Shared types and address map for the processor data-port controller.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LED,
    REG_HEX,
    REG_SW,
    REG_KEY,
    REG_NONE
  } region_t;

  localparam logic [15:0] LED_BASE  = 16'h1000;
  localparam logic [15:0] HEX_BASE  = 16'h2000;
  localparam logic [15:0] SW_ADDR   = 16'h3000;
  localparam logic [15:0] KEY_ADDR  = 16'h3001;
  localparam logic [6:0]  HEX_BLANK = 7'h7F;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a full-width data address to a region
// and, for the 7-segment block, the digit index.
module bus_addr_decode
  import data_bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int RAM_AW  = 12,
  parameter int NUM_HEX = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [2:0]        hex_idx
);

  logic [31:0] a32;
  logic [31:0] hex_off;

  always_comb begin
    a32     = 32'(addr);
    hex_off = a32 - 32'(HEX_BASE);
    region  = REG_NONE;
    // Full-width compares so upper address bits never alias onto a region
    if (a32 < (32'd1 << RAM_AW))
      region = REG_RAM;
    else if (a32 == 32'(LED_BASE))
      region = REG_LED;
    else if ((a32 >= 32'(HEX_BASE)) && (hex_off < 32'(NUM_HEX)))
      region = REG_HEX;
    else if (a32 == 32'(SW_ADDR))
      region = REG_SW;
    else if (a32 == 32'(KEY_ADDR))
      region = REG_KEY;
    hex_idx = 3'(hex_off);
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-port controller: decodes processor accesses to RAM / board I/O /
// unmapped space and stalls the processor with real wait states.
module data_bus_ctrl
  import data_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int RAM_AW      = 12,
  parameter int RAM_LATENCY = 1,
  parameter int WAIT_STATES = 0,
  parameter int NUM_HEX     = 6
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ADDR_W-1:0]    DataAddr,
  input  logic [DATA_W-1:0]    DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [DATA_W-1:0]    DataIn,
  output logic                 DataWaitreq,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic                 ram_we,
  input  logic [DATA_W-1:0]    ram_q,
  input  logic [9:0]           SW,
  input  logic [3:0]           KEY,
  output logic [9:0]           LEDR,
  output logic [7*NUM_HEX-1:0] HEX,
  output logic                 bus_err
);

  localparam int   CNT_W    = $clog2(RAM_LATENCY + WAIT_STATES + 2);
  localparam int   RD_RAM_N = RAM_LATENCY + WAIT_STATES - 1;
  localparam int   RD_IO_N  = WAIT_STATES;
  localparam int   WR_N     = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic WR_FAST  = (WAIT_STATES == 0);

  region_t           region;
  logic [2:0]        hex_idx;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_wait;
  logic              op_rd;
  logic              op_ram;
  logic [DATA_W-1:0] io_val;
  logic [DATA_W-1:0] io_q;
  logic [DATA_W-1:0] dreg;
  logic [9:0]        ledr_r;
  logic [6:0]        hex_r [8];
  logic              bus_err_r;
  logic [9:0]        sw_s1, sw_s2;
  logic [3:0]        key_s1, key_s2;
  logic              strobe, start, is_wr, is_rd, done;

  bus_addr_decode #(
    .ADDR_W (ADDR_W),
    .RAM_AW (RAM_AW),
    .NUM_HEX(NUM_HEX)
  ) u_dec (
    .addr   (DataAddr),
    .region (region),
    .hex_idx(hex_idx)
  );

  // Both strobes at once resolve to a write
  assign strobe = ReadData | WriteData;
  assign is_wr  = WriteData;
  assign is_rd  = ReadData & ~WriteData;
  assign start  = (state == IDLE) & strobe & ~Reset;
  assign done   = (state == RESP) | (start & is_wr & WR_FAST);

  assign DataWaitreq = ~Reset & strobe & ~done;
  assign ram_we      = start & is_wr & (region == REG_RAM);
  assign ram_addr    = DataAddr[RAM_AW-1:0];
  assign ram_wdata   = DataOut;
  assign DataIn      = ((state == RESP) && op_rd) ? (op_ram ? ram_q : io_q) : dreg;
  assign LEDR        = ledr_r;
  assign bus_err     = bus_err_r;

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign HEX[7*i +: 7] = hex_r[i];
  end

  always_comb begin
    io_val = '0;
    case (region)
      REG_LED: io_val = DATA_W'(ledr_r);
      REG_HEX: io_val = DATA_W'(hex_r[hex_idx]);
      REG_SW:  io_val = DATA_W'(sw_s2);
      REG_KEY: io_val = DATA_W'(key_s2);
      default: io_val = '0;
    endcase
  end

  // Number of WAIT cycles between the accepting IDLE cycle and RESP
  always_comb begin
    if (is_wr)
      n_wait = CNT_W'(WR_N);
    else if (region == REG_RAM)
      n_wait = CNT_W'(RD_RAM_N);
    else
      n_wait = CNT_W'(RD_IO_N);
  end

  // ---- input synchroniser ----
  always_ff @(posedge Clock) begin
    sw_s1  <= SW;
    sw_s2  <= sw_s1;
    key_s1 <= KEY;
    key_s2 <= key_s1;
  end

  always_ff @(posedge Clock) begin
    if (start)
      io_q <= io_val;
  end

  // ---- transfer FSM and MMIO registers ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_rd     <= 1'b0;
      op_ram    <= 1'b0;
      dreg      <= '0;
      ledr_r    <= '0;
      bus_err_r <= 1'b0;
      for (int i = 0; i < 8; i++)
        hex_r[i] <= HEX_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            op_rd  <= is_rd;
            op_ram <= (region == REG_RAM);
            if (is_wr && (region == REG_LED))
              ledr_r <= DataOut[9:0];
            if (is_wr && (region == REG_HEX))
              hex_r[hex_idx] <= DataOut[6:0];
            if ((region == REG_NONE) || (ReadData && WriteData))
              bus_err_r <= 1'b1;
            if (is_wr && WR_FAST)
              state <= IDLE;
            else if (n_wait == '0)
              state <= RESP;
            else begin
              state <= WAIT;
              cnt   <= n_wait - CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0)
            state <= RESP;
          else
            cnt <= cnt - CNT_W'(1);
        end
        RESP: begin
          state <= IDLE;
          if (op_rd)
            dreg <= DataIn;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: a default instance and a slow instance
// (RAM_LATENCY=3, WAIT_STATES=2), each with a behavioural RAM behind it.
module tb_data_bus_ctrl;

  logic        Clock, Reset;
  logic [15:0] DataAddr, DataOut;
  logic [9:0]  SW;
  logic [3:0]  KEY;

  logic        rd_a, wr_a, wait_a, we_a, err_a;
  logic [15:0] din_a, wdata_a, q_a;
  logic [11:0] addr_a;
  logic [9:0]  ledr_a;
  logic [41:0] hex_a;

  logic        rd_b, wr_b, wait_b, we_b, err_b;
  logic [15:0] din_b, wdata_b, q_b, q1_b, q2_b;
  logic [11:0] addr_b;
  logic [9:0]  ledr_b;
  logic [41:0] hex_b;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];
  logic [15:0] exp_q [$];

  int checks   = 0;
  int failures = 0;
  int wecnt_a  = 0;
  int wecnt_b  = 0;

  data_bus_ctrl u_dut_a (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(rd_a), .WriteData(wr_a), .DataIn(din_a), .DataWaitreq(wait_a),
    .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_we(we_a), .ram_q(q_a),
    .SW(SW), .KEY(KEY), .LEDR(ledr_a), .HEX(hex_a), .bus_err(err_a)
  );

  data_bus_ctrl #(.RAM_LATENCY(3), .WAIT_STATES(2)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(rd_b), .WriteData(wr_b), .DataIn(din_b), .DataWaitreq(wait_b),
    .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_we(we_b), .ram_q(q_b),
    .SW(SW), .KEY(KEY), .LEDR(ledr_b), .HEX(hex_b), .bus_err(err_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    q_a <= mem_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    q1_b <= mem_b[addr_b];
    q2_b <= q1_b;
    q_b  <= q2_b;
  end

  always @(negedge Clock) begin
    if (we_a) wecnt_a++;
    if (we_b) wecnt_b++;
  end

  task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 both strobes
  task automatic xfer(input bit b, input int kind, input logic [15:0] addr,
                      input logic [15:0] data, input int exp_cyc,
                      input logic [15:0] exp_rd, input string tag);
    int          cyc;
    bit          fin;
    logic [15:0] got, expv;
    DataAddr = addr;
    DataOut  = data;
    if (kind == 0) exp_q.push_back(exp_rd);
    if (b) begin rd_b = (kind != 1); wr_b = (kind != 0); end
    else   begin rd_a = (kind != 1); wr_a = (kind != 0); end
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge Clock);
      cyc++;
      if (!(b ? wait_b : wait_a)) begin
        fin = 1;
        if (kind == 0) begin
          got  = b ? din_b : din_a;
          expv = exp_q.pop_front();
          chk(64'(got), 64'(expv), {tag, "_data"});
        end
      end
      @(posedge Clock);
      #1;
    end
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    if (!fin && kind == 0) void'(exp_q.pop_front());
    chk(64'(cyc), 64'(exp_cyc), {tag, "_cycles"});
  endtask

  initial begin
    logic [41:0] hex_exp;
    int          w0;
    Reset = 1; rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    DataAddr = 0; DataOut = 0; SW = 0; KEY = 0;
    repeat (3) @(posedge Clock);
    #1 Reset = 0;
    @(negedge Clock);
    hex_exp = {6{7'h7F}};
    chk(64'(ledr_a), 64'(0), "rst_ledr");
    chk(64'(hex_a), 64'(hex_exp), "rst_hex");
    chk(64'(err_a), 64'(0), "rst_bus_err");
    chk(64'(din_a), 64'(0), "rst_datain");
    chk(64'(wait_a), 64'(0), "rst_waitreq");
    chk(64'(we_a), 64'(0), "rst_ram_we");
    @(posedge Clock); #1;

    // Default instance: RAM write then read back
    w0 = wecnt_a;
    xfer(0, 1, 16'h0005, 16'h1234, 1, 16'h0, "ram_wr");
    chk(64'(wecnt_a - w0), 64'(1), "ram_wr_we_pulses");
    xfer(0, 0, 16'h0005, 16'h0, 2, 16'h1234, "ram_rd");
    @(negedge Clock);
    chk(64'(din_a), 64'(16'h1234), "datain_hold");
    @(posedge Clock); #1;

    // LED / HEX registers
    xfer(0, 1, 16'h1000, 16'h03FF, 1, 16'h0, "led_wr");
    xfer(0, 1, 16'h2002, 16'h0040, 1, 16'h0, "hex_wr");
    @(negedge Clock);
    hex_exp[20:14] = 7'h40;
    chk(64'(ledr_a), 64'(10'h3FF), "ledr_val");
    chk(64'(hex_a), 64'(hex_exp), "hex_val");
    @(posedge Clock); #1;
    xfer(0, 0, 16'h2002, 16'h0, 2, 16'h0040, "hex_rd");
    xfer(0, 0, 16'h1000, 16'h0, 2, 16'h03FF, "led_rd");

    // Synchronised inputs
    SW = 10'h2A5;
    repeat (3) @(posedge Clock);
    #1;
    xfer(0, 0, 16'h3000, 16'h0, 2, 16'h02A5, "sw_rd");
    KEY = 4'hA;
    repeat (3) @(posedge Clock);
    #1;
    xfer(0, 0, 16'h3001, 16'h0, 2, 16'h000A, "key_rd");

    // Unmapped accesses
    w0 = wecnt_a;
    xfer(0, 1, 16'h5000, 16'hBEEF, 1, 16'h0, "unm_wr");
    @(negedge Clock);
    chk(64'(wecnt_a - w0), 64'(0), "unm_wr_no_we");
    chk(64'(ledr_a), 64'(10'h3FF), "unm_wr_ledr_kept");
    chk(64'(hex_a), 64'(hex_exp), "unm_wr_hex_kept");
    chk(64'(err_a), 64'(1), "unm_bus_err_set");
    @(posedge Clock); #1;
    xfer(0, 0, 16'h2006, 16'h0, 2, 16'h0000, "hex_past_end_rd");
    xfer(0, 0, 16'h0005, 16'h0, 2, 16'h1234, "ram_rd2");
    @(negedge Clock);
    chk(64'(err_a), 64'(1), "bus_err_sticky");
    @(posedge Clock); #1;

    // Slow instance: latency 3, two wait states
    w0 = wecnt_b;
    xfer(1, 1, 16'h0007, 16'hCAFE, 3, 16'h0, "b_ram_wr");
    chk(64'(wecnt_b - w0), 64'(1), "b_ram_wr_we_pulses");
    xfer(1, 0, 16'h0007, 16'h0, 6, 16'hCAFE, "b_ram_rd");
    xfer(1, 0, 16'h1000, 16'h0, 4, 16'h0000, "b_led_rd0");
    xfer(1, 1, 16'h1000, 16'h0155, 3, 16'h0, "b_led_wr");
    xfer(1, 0, 16'h1000, 16'h0, 4, 16'h0155, "b_led_rd");
    xfer(1, 1, 16'h5000, 16'h0001, 3, 16'h0, "b_unm_wr");
    @(negedge Clock);
    chk(64'(err_b), 64'(1), "b_bus_err_set");
    @(posedge Clock); #1;

    // Reset while a RAM read sits in WAIT
    DataAddr = 16'h0007;
    rd_b = 1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk(64'(wait_b), 64'(1), "b_wait_before_reset");
    @(posedge Clock); #1;
    Reset = 1;
    rd_b  = 0;
    @(posedge Clock); #1;
    Reset = 0;
    @(negedge Clock);
    hex_exp = {6{7'h7F}};
    chk(64'(wait_b), 64'(0), "b_rst_waitreq");
    chk(64'(ledr_b), 64'(0), "b_rst_ledr");
    chk(64'(hex_b), 64'(hex_exp), "b_rst_hex");
    chk(64'(err_b), 64'(0), "b_rst_bus_err");
    chk(64'(din_b), 64'(0), "b_rst_datain");
    chk(64'(ledr_a), 64'(0), "a_rst_ledr");
    @(posedge Clock); #1;
    xfer(1, 0, 16'h0007, 16'h0, 6, 16'hCAFE, "b_rd_after_reset");

    // Both strobes high: write semantics plus error flag
    xfer(0, 2, 16'h1000, 16'h0055, 1, 16'h0, "both_strobes");
    @(negedge Clock);
    chk(64'(ledr_a), 64'(10'h055), "both_ledr");
    chk(64'(err_a), 64'(1), "both_bus_err");
    chk(64'(exp_q.size()), 64'(0), "scoreboard_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
